bcd_scan_mux: RTL

//  Time-multiplexed front end for the 7-segment path: holds a multi-digit BCD word and scans it
//  one digit at a time. Each scanned nibble goes to display_decoder on its {x3,x2,x1,x0} inputs.
//  It also drives the active-low digit enables, with a dead-time gap between digits so no ghosting occurs.

---
 rtl/bcd_scan_mux.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/bcd_scan_mux.sv
`default_nettype none
// ============================================================================
// Module      : bcd_scan_mux
// Description : Time-multiplexed BCD scanner for a multi-digit 7-segment
//               display. It presents one digit nibble at a time to the segment
//               decoder and drives active-low digit enables. A blanking gap
//               between digits prevents ghosting. Loads are double-buffered
//               and are committed only at a frame boundary.
// Ports       :
//   clk         in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   load        in   1-cycle strobe, captures bcd_in into the shadow register
//   bcd_in      in   packed BCD value, nibble i = digit i
//   blank_lz    in   1 = suppress leading zeros (sampled every cycle)
//   load_ack    out  1-cycle pulse after the shadow value is committed
//   nibble      out  current digit code for the segment decoder
//   seg_blank   out  1 = the decoder output must be gated off
//   digit_en_n  out  active-low digit enables (all high during the gap)
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_scan_mux #(
   parameter int NUM_DIGITS   = 4,
   parameter int REFRESH_DIV  = 100000,
   parameter int BLANK_CYCLES = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] bcd_in,
   input  logic                    blank_lz,
   output logic                    load_ack,
   output logic [3:0]              nibble,
   output logic                    seg_blank,
   output logic [NUM_DIGITS-1:0]   digit_en_n
);

   localparam int CNT_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int DATA_W = 4 * NUM_DIGITS;

   localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(REFRESH_DIV - 1);
   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
   localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

   typedef enum logic [0:0] {
      ST_GAP  = 1'b0,
      ST_SHOW = 1'b1
   } state_t;

   // Current state
   state_t            state;
   logic [CNT_W-1:0]  slot_cnt;
   logic [IDX_W-1:0]  idx;
   logic [DATA_W-1:0] active;
   logic [DATA_W-1:0] shadow;
   logic              pending;

   // Next state
   state_t            state_nx;
   logic [CNT_W-1:0]  cnt_nx;
   logic [IDX_W-1:0]  idx_nx;
   logic [DATA_W-1:0] active_nx;
   logic [DATA_W-1:0] shadow_nx;
   logic              pending_nx;
   logic              ack_nx;
   logic              frame_end;

   // Next output values
   logic [3:0]            dig_nx [NUM_DIGITS];
   logic [NUM_DIGITS-1:0] lz_mask;
   logic                  zero_above;
   logic [3:0]            cur_digit;
   logic [3:0]            nibble_nx;
   logic                  blank_nx;
   logic [NUM_DIGITS-1:0] en_nx;

   // ------------------------------------------------------------------------
   // State register. Outputs are registered from next-state values so they
   // always line up with the state they describe.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_GAP;
         slot_cnt   <= '0;
         idx        <= '0;
         active     <= '0;
         shadow     <= '0;
         pending    <= 1'b0;
         load_ack   <= 1'b0;
         nibble     <= 4'd0;
         seg_blank  <= 1'b1;
         digit_en_n <= '1;
      end else begin
         state      <= state_nx;
         slot_cnt   <= cnt_nx;
         idx        <= idx_nx;
         active     <= active_nx;
         shadow     <= shadow_nx;
         pending    <= pending_nx;
         load_ack   <= ack_nx;
         nibble     <= nibble_nx;
         seg_blank  <= blank_nx;
         digit_en_n <= en_nx;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state logic: slot timing, digit index and load handshake
   // ------------------------------------------------------------------------
   always_comb begin
      state_nx   = state;
      cnt_nx     = (slot_cnt == CNT_LAST) ? '0 : slot_cnt + CNT_W'(1);
      idx_nx     = idx;
      active_nx  = active;
      shadow_nx  = shadow;
      pending_nx = pending;
      ack_nx     = 1'b0;
      frame_end  = 1'b0;

      // Last load wins: a new strobe simply overwrites the shadow copy.
      if (load) begin
         shadow_nx  = bcd_in;
         pending_nx = 1'b1;
      end

      case (state)
         ST_GAP: begin
            if (slot_cnt == BLANK_LAST) begin
               state_nx = ST_SHOW;
            end
         end
         ST_SHOW: begin
            if (slot_cnt == CNT_LAST) begin
               state_nx = ST_GAP;
               if (idx == IDX_LAST) begin
                  idx_nx    = '0;
                  frame_end = 1'b1;
               end else begin
                  idx_nx = idx + IDX_W'(1);
               end
            end
         end
         default: begin
            state_nx = ST_GAP;
         end
      endcase

      // A strobe landing on the boundary cycle bypasses the shadow so it is
      // not deferred by a whole frame.
      if (frame_end && (pending || load)) begin
         active_nx  = load ? bcd_in : shadow;
         pending_nx = 1'b0;
         ack_nx     = 1'b1;
      end
   end

   // ------------------------------------------------------------------------
   // Output decode from the next-state values
   // ------------------------------------------------------------------------
   generate
      for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
         assign dig_nx[g] = active_nx[4*g +: 4];
      end
   endgenerate

   always_comb begin
      // lz_mask[i] = digit i and every more significant digit are zero
      zero_above = 1'b1;
      lz_mask    = '0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         zero_above = zero_above & (dig_nx[i] == 4'd0);
         lz_mask[i] = zero_above;
      end

      cur_digit = dig_nx[idx_nx];
      nibble_nx = cur_digit;
      blank_nx  = 1'b1;
      en_nx     = '1;

      if (state_nx == ST_SHOW) begin
         en_nx[idx_nx] = 1'b0;
         // Invalid codes are passed through raw but gated off; digit 0 is
         // never zero-suppressed so a value of 0 still shows one digit.
         blank_nx = (cur_digit > 4'd9) ||
                    (blank_lz && (idx_nx != '0) && lz_mask[idx_nx]);
      end
   end

endmodule
`default_nettype wire
